// File: rtl/digital_clock_pkg.sv
// Shared encodings and field limits for the digital clock and its time counters.
package digital_clock_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK      = 2'd0,
    MODE_STOPWATCH  = 2'd1,
    MODE_ALARM_EDIT = 2'd2,
    MODE_CLOCK_EDIT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    SELECT_NONE = 2'd0,
    SELECT_SEC  = 2'd1,
    SELECT_MIN  = 2'd2,
    SELECT_HOUR = 2'd3
  } select_e;

  localparam logic [6:0] CS_MAX   = 7'd99;
  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  function automatic logic [5:0] wrap_inc60(input logic [5:0] v, input logic [5:0] max);
    return (v == max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] wrap_inc24(input logic [4:0] v);
    return (v == HOUR_MAX) ? 5'd0 : v + 5'd1;
  endfunction

endpackage

// File: rtl/digital_clock_time_counter.sv
// hh:mm:ss.cc counter with clear, per-field wrap-only edits and a full carry chain on enable.
module time_counter
  import digital_clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       inc_sec,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [6:0] cs,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour
);

  logic [6:0] cs_q, cs_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;

  // Clear beats edits, edits beat counting; edits never carry into the next field.
  always_comb begin
    cs_d   = cs_q;
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    if (clr) begin
      cs_d   = '0;
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else if (inc_sec) begin
      sec_d = wrap_inc60(sec_q, SEC_MAX);
      cs_d  = '0;
    end else if (inc_min) begin
      min_d = wrap_inc60(min_q, MIN_MAX);
    end else if (inc_hour) begin
      hour_d = wrap_inc24(hour_q);
    end else if (en) begin
      if (cs_q == CS_MAX) begin
        cs_d = '0;
        if (sec_q == SEC_MAX) begin
          sec_d = '0;
          if (min_q == MIN_MAX) begin
            min_d  = '0;
            hour_d = wrap_inc24(hour_q);
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        cs_d = cs_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q   <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else begin
      cs_q   <= cs_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
    end
  end

  assign cs   = cs_q;
  assign sec  = sec_q;
  assign min  = min_q;
  assign hour = hour_q;

endmodule

// File: rtl/digital_clock.sv
// Time-of-day clock with stopwatch, editable alarm and a mode-selected display.
module digital_clock
  import digital_clock_pkg::*;
#(
  parameter int TICKS_PER_CS = 1
) (
  input  logic       clk,
  input  logic       global_reset,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [1:0] select,
  input  logic       increment,
  input  logic       alarm_enable,
  output logic [6:0] ms_out,
  output logic [5:0] sec_out,
  output logic [5:0] min_out,
  output logic [4:0] hour_out,
  output logic       alarm_out
);

  localparam int PRE_W = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;

  mode_e   mode_s;
  select_e sel_s;
  assign mode_s = mode_e'(mode);
  assign sel_s  = select_e'(select);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  logic             inc_prev_q, inc_prev_d;
  logic             inc_edge;
  logic             run_q, run_d;
  logic             alarm_q, alarm_d;
  logic [5:0]       alm_sec_q, alm_sec_d;
  logic [5:0]       alm_min_q, alm_min_d;
  logic [4:0]       alm_hour_q, alm_hour_d;

  logic [6:0] tod_cs, sw_cs;
  logic [5:0] tod_sec, sw_sec, tod_min, sw_min;
  logic [4:0] tod_hour, sw_hour;

  logic tod_en, tod_clr, tod_inc_sec, tod_inc_min, tod_inc_hour;
  logic sw_en, sw_clr, alarm_match;

  assign tick     = (pre_q == PRE_W'(TICKS_PER_CS - 1));
  assign inc_edge = increment & ~inc_prev_q;

  always_comb begin
    pre_d      = tick ? '0 : pre_q + PRE_W'(1);
    inc_prev_d = increment;
  end

  always_comb begin
    tod_en       = tick && (mode_s != MODE_CLOCK_EDIT);
    tod_clr      = reset && (mode_s == MODE_CLOCK || mode_s == MODE_CLOCK_EDIT);
    tod_inc_sec  = inc_edge && (mode_s == MODE_CLOCK_EDIT) && (sel_s == SELECT_SEC);
    tod_inc_min  = inc_edge && (mode_s == MODE_CLOCK_EDIT) && (sel_s == SELECT_MIN);
    tod_inc_hour = inc_edge && (mode_s == MODE_CLOCK_EDIT) && (sel_s == SELECT_HOUR);
    sw_en        = tick && run_q;
    sw_clr       = reset && (mode_s == MODE_STOPWATCH);
  end

  time_counter u_tod (
    .clk      (clk),
    .rst_n    (global_reset),
    .en       (tod_en),
    .clr      (tod_clr),
    .inc_sec  (tod_inc_sec),
    .inc_min  (tod_inc_min),
    .inc_hour (tod_inc_hour),
    .cs       (tod_cs),
    .sec      (tod_sec),
    .min      (tod_min),
    .hour     (tod_hour)
  );

  time_counter u_sw (
    .clk      (clk),
    .rst_n    (global_reset),
    .en       (sw_en),
    .clr      (sw_clr),
    .inc_sec  (1'b0),
    .inc_min  (1'b0),
    .inc_hour (1'b0),
    .cs       (sw_cs),
    .sec      (sw_sec),
    .min      (sw_min),
    .hour     (sw_hour)
  );

  // Run flag and alarm time only react in their own modes; reset wins over an edge.
  always_comb begin
    run_d      = run_q;
    alm_sec_d  = alm_sec_q;
    alm_min_d  = alm_min_q;
    alm_hour_d = alm_hour_q;
    if (mode_s == MODE_STOPWATCH) begin
      if (reset) run_d = 1'b0;
      else if (inc_edge) run_d = ~run_q;
    end
    if (mode_s == MODE_ALARM_EDIT) begin
      if (reset) begin
        alm_sec_d  = '0;
        alm_min_d  = '0;
        alm_hour_d = '0;
      end else if (inc_edge) begin
        case (sel_s)
          SELECT_SEC:  alm_sec_d  = wrap_inc60(alm_sec_q, SEC_MAX);
          SELECT_MIN:  alm_min_d  = wrap_inc60(alm_min_q, MIN_MAX);
          SELECT_HOUR: alm_hour_d = wrap_inc24(alm_hour_q);
          default: ;
        endcase
      end
    end
  end

  assign alarm_match = (tod_sec == alm_sec_q) && (tod_min == alm_min_q) && (tod_hour == alm_hour_q);

  always_comb begin
    alarm_d = alarm_enable && (alarm_q || alarm_match);
  end

  always_ff @(posedge clk or negedge global_reset) begin
    if (!global_reset) begin
      pre_q      <= '0;
      inc_prev_q <= 1'b0;
      run_q      <= 1'b0;
      alarm_q    <= 1'b0;
      alm_sec_q  <= '0;
      alm_min_q  <= '0;
      alm_hour_q <= '0;
    end else begin
      pre_q      <= pre_d;
      inc_prev_q <= inc_prev_d;
      run_q      <= run_d;
      alarm_q    <= alarm_d;
      alm_sec_q  <= alm_sec_d;
      alm_min_q  <= alm_min_d;
      alm_hour_q <= alm_hour_d;
    end
  end

  always_comb begin
    ms_out   = tod_cs;
    sec_out  = tod_sec;
    min_out  = tod_min;
    hour_out = tod_hour;
    case (mode_s)
      MODE_STOPWATCH: begin
        ms_out   = sw_cs;
        sec_out  = sw_sec;
        min_out  = sw_min;
        hour_out = sw_hour;
      end
      MODE_ALARM_EDIT: begin
        ms_out   = '0;
        sec_out  = alm_sec_q;
        min_out  = alm_min_q;
        hour_out = alm_hour_q;
      end
      default: ;
    endcase
  end

  assign alarm_out = alarm_q;

endmodule

// File: tb/tb_digital_clock.sv
// Randomized and directed bench for digital_clock against a total-hundredths reference model.
module tb_digital_clock;

  localparam int TICKS  = 1;
  localparam int DAY_CS = 8640000;

  logic       clk = 1'b0;
  logic       global_reset;
  logic       reset;
  logic [1:0] mode;
  logic [1:0] select;
  logic       increment;
  logic       alarm_enable;
  logic [6:0] ms_out;
  logic [5:0] sec_out;
  logic [5:0] min_out;
  logic [4:0] hour_out;
  logic       alarm_out;

  always #5 clk = ~clk;

  digital_clock #(.TICKS_PER_CS(TICKS)) dut (
    .clk          (clk),
    .global_reset (global_reset),
    .reset        (reset),
    .mode         (mode),
    .select       (select),
    .increment    (increment),
    .alarm_enable (alarm_enable),
    .ms_out       (ms_out),
    .sec_out      (sec_out),
    .min_out      (min_out),
    .hour_out     (hour_out),
    .alarm_out    (alarm_out)
  );

  wire [24:0] dut_vec = {ms_out, sec_out, min_out, hour_out, alarm_out};

  int checks = 0;
  int errors = 0;

  // Reference state: times as plain hundredths (alarm in whole seconds).
  int m_tod, m_sw, m_alarm, m_pre;
  bit m_run, m_prev, m_aout;

  function automatic int edit_field(input int t, input int sel);
    int h, mi, s, c;
    h  = t / 360000;
    mi = (t / 6000) % 60;
    s  = (t / 100) % 60;
    c  = t % 100;
    case (sel)
      1: begin s = (s + 1) % 60; c = 0; end
      2: mi = (mi + 1) % 60;
      3: h = (h + 1) % 24;
      default: ;
    endcase
    return ((h * 60 + mi) * 60 + s) * 100 + c;
  endfunction

  function automatic logic [24:0] exp_vec();
    int t;
    case (mode)
      2'd1:    t = m_sw;
      2'd2:    t = m_alarm * 100;
      default: t = m_tod;
    endcase
    return {7'(t % 100), 6'((t / 100) % 60), 6'((t / 6000) % 60), 5'(t / 360000), m_aout};
  endfunction

  task automatic model_reset();
    m_tod = 0; m_sw = 0; m_alarm = 0; m_pre = 0;
    m_run = 0; m_prev = 0; m_aout = 0;
  endtask

  task automatic model_step();
    bit e, tk, n_run, n_aout;
    int n_tod, n_sw, n_alarm;
    e       = increment && !m_prev;
    tk      = (m_pre == TICKS - 1);
    n_tod   = m_tod;
    n_sw    = m_sw;
    n_alarm = m_alarm;
    n_run   = m_run;
    n_aout  = alarm_enable && (m_aout || (m_tod / 100 == m_alarm));
    if (reset && (mode == 2'd0 || mode == 2'd3)) n_tod = 0;
    else if (mode == 2'd3) begin
      if (e) n_tod = edit_field(m_tod, int'(select));
    end else if (tk) n_tod = (m_tod + 1) % DAY_CS;
    if (reset && mode == 2'd1) begin
      n_sw = 0; n_run = 0;
    end else begin
      if (m_run && tk) n_sw = (m_sw + 1) % DAY_CS;
      if (mode == 2'd1 && e) n_run = !m_run;
    end
    if (mode == 2'd2) begin
      if (reset) n_alarm = 0;
      else if (e) n_alarm = edit_field(m_alarm * 100, int'(select)) / 100;
    end
    m_tod = n_tod; m_sw = n_sw; m_alarm = n_alarm; m_run = n_run; m_aout = n_aout;
    m_prev = increment;
    m_pre  = tk ? 0 : m_pre + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic inc_pulse();
    increment = 1'b1; tick();
    increment = 1'b0; tick();
  endtask

  // Assert global reset between edges and release it on a falling edge.
  task automatic greset();
    #2 global_reset = 1'b0;
    #1 model_reset();
    @(negedge clk);
    global_reset = 1'b1;
  endtask

  task automatic test_reset();
    global_reset = 1'b1;
    #1 global_reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== 25'd0) begin
      errors++; $display("FAIL reset_async got %h exp %h", dut_vec, 25'd0);
    end
    @(negedge clk);
    global_reset = 1'b1;
    checks++;
    if (dut_vec !== 25'd0) begin
      errors++; $display("FAIL reset_release got %h exp %h", dut_vec, 25'd0);
    end
    tick();
    checks++;
    if (dut_vec !== exp_vec() || ms_out !== 7'd1) begin
      errors++; $display("FAIL first_edge got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_count();
    mode = 2'd0;
    greset();
    repeat (150) tick();
    checks++;
    if (dut_vec !== {7'd50, 6'd1, 6'd0, 5'd0, 1'b0}) begin
      errors++; $display("FAIL count150 got %h exp %h", dut_vec, {7'd50, 6'd1, 6'd0, 5'd0, 1'b0});
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL count150_model got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_wrap();
    mode = 2'd3;
    greset();
    select = 2'd3; repeat (23) inc_pulse();
    select = 2'd2; repeat (59) inc_pulse();
    select = 2'd1; repeat (59) inc_pulse();
    checks++;
    if (dut_vec !== {7'd0, 6'd59, 6'd59, 5'd23, 1'b0}) begin
      errors++; $display("FAIL preload got %h exp %h", dut_vec, {7'd0, 6'd59, 6'd59, 5'd23, 1'b0});
    end
    mode = 2'd0; select = 2'd0;
    repeat (100) tick();
    checks++;
    if (dut_vec !== 25'd0 || exp_vec() !== 25'd0) begin
      errors++; $display("FAIL day_wrap got %h exp %h", dut_vec, 25'd0);
    end
  endtask

  task automatic test_stopwatch();
    logic [24:0] tod_snap;
    mode = 2'd1;
    increment = 1'b1; tick();
    increment = 1'b0; repeat (24) tick();
    increment = 1'b1; tick();
    increment = 1'b0; repeat (10) tick();
    checks++;
    if (dut_vec !== {7'd25, 6'd0, 6'd0, 5'd0, 1'b0} || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL sw_hold got %h exp %h", dut_vec, {7'd25, 6'd0, 6'd0, 5'd0, 1'b0});
    end
    tod_snap = {7'(m_tod % 100), 6'((m_tod / 100) % 60), 6'((m_tod / 6000) % 60), 5'(m_tod / 360000), 1'b0};
    reset = 1'b1; tick();
    reset = 1'b0;
    checks++;
    if (dut_vec !== 25'd0) begin
      errors++; $display("FAIL sw_reset got %h exp %h", dut_vec, 25'd0);
    end
    repeat (5) tick();
    mode = 2'd0;
    #1;
    checks++;
    if (dut_vec !== exp_vec() || dut_vec === tod_snap) begin
      errors++; $display("FAIL tod_runs got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_alarm();
    mode = 2'd2; alarm_enable = 1'b0;
    greset();
    select = 2'd1; repeat (2) inc_pulse();
    checks++;
    if (dut_vec !== {7'd0, 6'd2, 6'd0, 5'd0, 1'b0}) begin
      errors++; $display("FAIL alarm_set got %h exp %h", dut_vec, {7'd0, 6'd2, 6'd0, 5'd0, 1'b0});
    end
    mode = 2'd0; select = 2'd0;
    reset = 1'b1; tick();
    reset = 1'b0; alarm_enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL alarm_run cyc %0d got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (alarm_out !== 1'b1) begin
      errors++; $display("FAIL alarm_latched got %b exp 1", alarm_out);
    end
    alarm_enable = 1'b0; tick();
    checks++;
    if (alarm_out !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL alarm_clear got %b exp 0", alarm_out);
    end
  endtask

  task automatic test_edit_hour();
    logic [24:0] snap;
    mode = 2'd0;
    repeat ($urandom_range(50, 500)) tick();
    mode = 2'd3;
    #1 snap = exp_vec();
    select = 2'd3; repeat (24) inc_pulse();
    checks++;
    if (dut_vec !== snap || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL hour_roundtrip got %h exp %h", dut_vec, snap);
    end
    select = 2'd0; repeat (3) inc_pulse();
    checks++;
    if (dut_vec !== snap) begin
      errors++; $display("FAIL select_none got %h exp %h", dut_vec, snap);
    end
    mode = 2'd0; repeat (3) inc_pulse();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL clock_inc_ignored got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      mode         = 2'($urandom_range(0, 3));
      select       = 2'($urandom_range(0, 3));
      increment    = 1'($urandom_range(0, 1));
      reset        = ($urandom_range(0, 31) == 0);
      alarm_enable = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d got %h exp %h", i, dut_vec, exp_vec());
      end
    end
    reset = 1'b0; increment = 1'b0; alarm_enable = 1'b0;
  endtask

  task automatic test_async_reset();
    mode = 2'd0;
    repeat ($urandom_range(20, 200)) tick();
    #3 global_reset = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 25'd0) begin
      errors++; $display("FAIL midcount_reset got %h exp %h", dut_vec, 25'd0);
    end
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (dut_vec !== 25'd0) begin
      errors++; $display("FAIL reset_held got %h exp %h", dut_vec, 25'd0);
    end
    @(negedge clk);
    global_reset = 1'b1;
    tick();
    checks++;
    if (dut_vec !== exp_vec() || ms_out !== 7'd1) begin
      errors++; $display("FAIL resume got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; mode = 2'd0; select = 2'd0;
    increment = 1'b0; alarm_enable = 1'b0;
    model_reset();
    test_reset();
    test_count();
    test_wrap();
    test_stopwatch();
    test_alarm();
    test_edit_hour();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digital_clock.md
DIGITAL_CLOCK -- requirements
Module: digital_clock

Interface
REQ-001 Parameter TICKS_PER_CS, default 1: clk cycles per hundredth-second tick.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 global_reset  input  1  asynchronous, active-low reset of all state.
REQ-004 reset  input  1  synchronous, active-high clear of the mode-selected counter.
REQ-005 mode  input  2  0 CLOCK, 1 STOPWATCH, 2 ALARM_EDIT, 3 CLOCK_EDIT.
REQ-006 select  input  2  0 NONE, 1 SEC, 2 MIN, 3 HOUR; field edited in the edit modes.
REQ-007 increment  input  1  level input; only its sampled rising edge acts (inc=1 while previous sample=0).
REQ-008 alarm_enable  input  1  level; arms the alarm.
REQ-009 ms_out  output  7  displayed hundredths, 0..99.
REQ-010 sec_out  output  6  displayed seconds, 0..59.
REQ-011 min_out  output  6  displayed minutes, 0..59.
REQ-012 hour_out  output  5  displayed hours, 0..23.
REQ-013 alarm_out  output  1  alarm indication, registered.

Function
REQ-014 Time-of-day counter SHALL advance one hundredth every TICKS_PER_CS cycles in all modes except CLOCK_EDIT, where it SHALL hold.
REQ-015 Carry chain: hundredths 99->0 carries to sec; 59->0 carries to min; 59->0 carries to hour; hour 23->0; 23:59:59.99 SHALL wrap to 00:00:00.00.
REQ-016 Stopwatch SHALL use the same format and carry rules; it counts only while its run flag is set, in any mode.
REQ-017 In STOPWATCH mode, an increment rising edge SHALL toggle the run flag.
REQ-018 reset=1 SHALL clear, on the next edge: CLOCK or CLOCK_EDIT: time-of-day to 00:00:00.00; STOPWATCH: stopwatch to zero and run flag to 0; ALARM_EDIT: alarm time to 00:00:00.
REQ-019 In CLOCK_EDIT, an increment edge SHALL add 1 to the selected time-of-day field with wrap (sec/min 59->0, hour 23->0) and no carry; SEC edit also SHALL zero hundredths.
REQ-020 In ALARM_EDIT, an increment edge SHALL add 1 to the selected alarm field with the same wrap and no carry.
REQ-021 select=NONE: increment edges in edit modes SHALL have no effect; increment edges in CLOCK mode SHALL have no effect.
REQ-022 reset and an increment edge in the same cycle: reset SHALL win.
REQ-023 Display mux (combinational from registers): CLOCK/CLOCK_EDIT -> time-of-day; STOPWATCH -> stopwatch; ALARM_EDIT -> alarm h:m:s with ms_out=0.
REQ-024 alarm_out SHALL set when alarm_enable=1 and time-of-day h:m:s equals the alarm h:m:s, and stay set until alarm_enable=0 (clears next edge) or global reset.
REQ-025 A mode change SHALL NOT alter any counter; the increment edge detector SHALL run in all modes.

Reset
REQ-026 global_reset=0 SHALL asynchronously clear time-of-day, stopwatch, run flag, alarm time, prescaler, increment history and alarm_out to 0; all outputs read 0.
REQ-027 On global_reset release, counting SHALL resume on the first subsequent edge.

Structure
REQ-028 Package digital_clock_pkg SHALL hold the MODE_* and SELECT_* encodings and field maxima (99, 59, 23).
REQ-029 One sub-module time_counter (hundredths/sec/min/hour with enable, clear, carry) SHALL be instantiated twice: time-of-day and stopwatch.

Verification
REQ-030 Global reset, mode=CLOCK, TICKS_PER_CS=1, 150 cycles -> 00:00:01.50; alarm_out=0.
REQ-031 Preload via CLOCK_EDIT to 23:59:59, return to CLOCK, 100 cycles -> 00:00:00.00.
REQ-032 STOPWATCH: increment edge, 25 cycles, edge -> shows 00:00:00.25 and holds; reset -> 00:00:00.00 while time-of-day keeps counting.
REQ-033 ALARM_EDIT select=SEC, 2 edges -> alarm 00:00:02, ms_out=0; CLOCK, alarm_enable=1 after global reset -> alarm_out=1 once time-of-day reaches 00:00:02, 0 one cycle after alarm_enable=0.
REQ-034 CLOCK_EDIT select=HOUR, 24 edges -> hour_out returns to original; min/sec unchanged; time held during edit.
REQ-035 global_reset asserted mid-count, asynchronously between edges -> all outputs 0 immediately.
